// File: rtl/key_event_encoder_pkg.sv
// Shared types and helpers for the key event encoder: bus widths, the
// output FSM state type and the key-vector encode/decode functions.
package key_event_encoder_pkg;

    localparam int KEY_W  = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } evt_state_e;

    // One-hot expansion of a 3-bit key index.
    function automatic logic [KEY_W-1:0] onehot8(input logic [CODE_W-1:0] code);
        logic [KEY_W-1:0] vec;
        vec       = '0;
        vec[code] = 1'b1;
        return vec;
    endfunction

    // Index of the highest set bit; bit 7 has priority. Returns 0 for an all-zero vector.
    function automatic logic [CODE_W-1:0] prio_enc8(input logic [KEY_W-1:0] vec);
        logic [CODE_W-1:0] code;
        code = '0;
        for (int i = 0; i < KEY_W; i++) begin
            if (vec[i]) begin
                code = CODE_W'(i);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/key_debounce8.sv
// Synchronises eight raw button lines, debounces the vector as a whole and
// produces a one-cycle rise strobe for keys that newly become pressed.
module key_debounce8
    import key_event_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key_stable,
    output logic [KEY_W-1:0] rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [KEY_W-1:0] s1_q,         s1_d;
    logic [KEY_W-1:0] key_sync_q,   key_sync_d;
    logic [KEY_W-1:0] cand_q,       cand_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [KEY_W-1:0] key_stable_q, key_stable_d;
    logic             accept;

    // Next-state for the synchroniser, candidate/counter and accepted vector.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        s1_d         = key_in;
        key_sync_d   = s1_q;
        cand_d       = cand_q;
        cnt_d        = cnt_q;
        key_stable_d = key_stable_q;
        accept       = 1'b0;

        if (key_sync_q != cand_q) begin
            // Any bit change restarts the stability count for the whole vector.
            cand_d = key_sync_q;
            cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Stable long enough; the counter parks here so it can never wrap.
            accept       = 1'b1;
            key_stable_d = cand_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Newly pressed keys, only on a cycle where the accepted vector is refreshed.
    assign rise       = accept ? (cand_q & ~key_stable_q) : '0;
    assign key_stable = key_stable_q;

    // State registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q         <= '0;
            key_sync_q   <= '0;
            cand_q       <= '0;
            cnt_q        <= '0;
            key_stable_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            s1_q         <= s1_d;
            key_sync_q   <= key_sync_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            key_stable_q <= key_stable_d;
        end
    end

endmodule

// File: rtl/key_event_encoder.sv
// Source side of the 8-bit key/enable bus: debounced key vector, "any key"
// enable, and one encoded valid/ready event per new key press with a sticky
// overflow flag for presses that could not be delivered.
module key_event_encoder
    import key_event_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              evt_ready,
    input  logic              clr_ovf,
    output logic              evt_valid,
    output logic [CODE_W-1:0] evt_code,
    output logic [KEY_W-1:0]  evt_onehot,
    output logic [KEY_W-1:0]  key_stable,
    output logic              any_pressed,
    output logic              ovf
);

    localparam logic [KEY_W-1:0] ONE = KEY_W'(1);

    logic [KEY_W-1:0]  rise;
    evt_state_e        state_q,      state_d;
    logic [CODE_W-1:0] evt_code_q,   evt_code_d;
    logic [KEY_W-1:0]  evt_onehot_q, evt_onehot_d;
    logic              ovf_q,        ovf_d;
    logic              ovf_set;
    logic              multi_rise;

    key_debounce8 #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_stable (key_stable),
        .rise       (rise)
    );

    // More than one key rose together: only the highest one can be reported.
    assign multi_rise = (rise & (rise - ONE)) != '0;

    // Output FSM next-state, event payload and overflow detection.
    always_comb begin
        state_d      = state_q;
        evt_code_d   = evt_code_q;
        evt_onehot_d = evt_onehot_q;
        ovf_set      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rise != '0) begin
                    evt_code_d   = prio_enc8(rise);
                    evt_onehot_d = onehot8(prio_enc8(rise));
                    state_d      = ST_HOLD;
                    ovf_set      = multi_rise;
                end
            end
            ST_HOLD: begin
                if (evt_ready) begin
                    if (rise != '0) begin
                        // Transfer completes and the next event loads with no bubble.
                        evt_code_d   = prio_enc8(rise);
                        evt_onehot_d = onehot8(prio_enc8(rise));
                        ovf_set      = multi_rise;
                    end else begin
                        evt_code_d   = '0;
                        evt_onehot_d = '0;
                        state_d      = ST_IDLE;
                    end
                end else if (rise != '0) begin
                    // Consumer stalled: the current event stays, the new press is lost.
                    ovf_set = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A set in the same cycle as a clear leaves the flag set.
        ovf_d = ovf_set | (ovf_q & ~clr_ovf);
    end

    // FSM state, event payload and overflow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            evt_code_q   <= '0;
            evt_onehot_q <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            evt_code_q   <= evt_code_d;
            evt_onehot_q <= evt_onehot_d;
            ovf_q        <= ovf_d;
        end
    end

    assign evt_valid   = (state_q == ST_HOLD);
    assign evt_code    = evt_code_q;
    assign evt_onehot  = evt_onehot_q;
    assign ovf         = ovf_q;
    assign any_pressed = |key_stable;

endmodule

// File: tb/tb_key_event_encoder.sv
// Self-checking bench for key_event_encoder (DEBOUNCE_CYCLES=4): expected
// event codes are queued when a press is driven and popped when the DUT
// presents the event.
module tb_key_event_encoder;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] key_in;
    logic       evt_ready;
    logic       clr_ovf;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic [7:0] evt_onehot;
    logic [7:0] key_stable;
    logic       any_pressed;
    logic       ovf;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [2:0] exp_q[$];

    key_event_encoder #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .evt_ready   (evt_ready),
        .clr_ovf     (clr_ovf),
        .evt_valid   (evt_valid),
        .evt_code    (evt_code),
        .evt_onehot  (evt_onehot),
        .key_stable  (key_stable),
        .any_pressed (any_pressed),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait up to budget edges for evt_valid; reports whether it was seen.
    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (evt_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // Pop the expected code and compare it with the presented event.
    task automatic score_event(input string name);
        logic [2:0] exp_code;
        logic [7:0] exp_oh;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: event code %0d presented but none expected", name, evt_code);
        end else begin
            exp_code = exp_q.pop_front();
            exp_oh   = 8'h01 << exp_code;
            if (evt_code !== exp_code || evt_onehot !== exp_oh) begin
                n_bad++;
                $display("FAIL %s: code/onehot got %0d/%h want %0d/%h",
                         name, evt_code, evt_onehot, exp_code, exp_oh);
            end
        end
    endtask

    // Release all keys and drain; leaves the DUT idle with ovf cleared.
    task automatic go_idle();
        key_in    = 8'h00;
        evt_ready = 1'b1;
        repeat (3 * D + 6) tick();
        evt_ready = 1'b0;
        clr_ovf   = 1'b1;
        tick();
        clr_ovf   = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        key_in    = 8'h00;
        evt_ready = 1'b0;
        clr_ovf   = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({evt_valid, evt_code, evt_onehot, key_stable, any_pressed, ovf} !== 22'h0) begin
            n_bad++;
            $display("FAIL reset: valid=%b code=%0d oh=%h stable=%h any=%b ovf=%b want all 0",
                     evt_valid, evt_code, evt_onehot, key_stable, any_pressed, ovf);
        end
        rst = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (evt_valid !== 1'b0 || key_stable !== 8'h00) begin
            n_bad++;
            $display("FAIL post_reset_idle: valid=%b stable=%h want 0/00", evt_valid, key_stable);
        end
    endtask

    task automatic test_single_press();
        key_in = 8'h04;
        exp_q.push_back(3'd2);
        for (int e = 1; e < D + 3; e++) begin
            tick();
            n_cmp++;
            if (evt_valid !== 1'b0 || key_stable !== 8'h00) begin
                n_bad++;
                $display("FAIL early_accept edge %0d: valid=%b stable=%h want 0/00", e, evt_valid, key_stable);
            end
        end
        tick();
        n_cmp++;
        if (evt_valid !== 1'b1 || key_stable !== 8'h04 || any_pressed !== 1'b1) begin
            n_bad++;
            $display("FAIL accept_edge: valid=%b stable=%h any=%b want 1/04/1", evt_valid, key_stable, any_pressed);
        end
        score_event("single_press");
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if (evt_valid !== 1'b1 || evt_code !== 3'd2 || ovf !== 1'b0) begin
                n_bad++;
                $display("FAIL held_key cycle %0d: valid=%b code=%0d ovf=%b want 1/2/0", i, evt_valid, evt_code, ovf);
            end
        end
        evt_ready = 1'b1;
        tick();
        n_cmp++;
        if (evt_valid !== 1'b0 || evt_code !== 3'd0 || evt_onehot !== 8'h00) begin
            n_bad++;
            $display("FAIL accept_clears: valid=%b code=%0d oh=%h want 0/0/00", evt_valid, evt_code, evt_onehot);
        end
        repeat (6) tick();
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL held_no_second_event: valid=%b want 0", evt_valid);
        end
        go_idle();
        n_cmp++;
        if (key_stable !== 8'h00 || any_pressed !== 1'b0 || evt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL release_no_event: stable=%h any=%b valid=%b want 00/0/0", key_stable, any_pressed, evt_valid);
        end
    endtask

    task automatic test_bounce();
        int bad_cycles;
        bad_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            key_in = ((i / 2) % 2 == 0) ? 8'h10 : 8'h00;
            tick();
            if (key_stable !== 8'h00 || evt_valid !== 1'b0) bad_cycles++;
        end
        key_in = 8'h00;
        repeat (2 * D + 4) begin
            tick();
            if (key_stable !== 8'h00 || evt_valid !== 1'b0) bad_cycles++;
        end
        n_cmp++;
        if (bad_cycles !== 0) begin
            n_bad++;
            $display("FAIL bounce: %0d cycles with stable/valid changed, want 0", bad_cycles);
        end
    endtask

    task automatic test_multi_press();
        bit seen;
        key_in = 8'h81;
        exp_q.push_back(3'd7);
        wait_valid(D + 6, seen);
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL multi_press_timeout: valid=%b want 1", evt_valid);
        end
        score_event("multi_press");
        n_cmp++;
        if (ovf !== 1'b1 || key_stable !== 8'h81) begin
            n_bad++;
            $display("FAIL multi_press_ovf: ovf=%b stable=%h want 1/81", ovf, key_stable);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        tick();
        n_cmp++;
        if (ovf !== 1'b0 || evt_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_ovf: ovf=%b valid=%b want 0/1", ovf, evt_valid);
        end
        go_idle();
    endtask

    task automatic test_drop_when_stalled();
        bit seen;
        key_in = 8'h04;
        exp_q.push_back(3'd2);
        wait_valid(D + 6, seen);
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL stall_first_timeout: valid=%b want 1", evt_valid);
        end
        score_event("stall_first");
        key_in = 8'h0C;
        repeat (D + 2) tick();
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_ovf_early: ovf=%b want 0", ovf);
        end
        tick();
        n_cmp++;
        if (ovf !== 1'b1 || evt_valid !== 1'b1 || evt_code !== 3'd2 || key_stable !== 8'h0C) begin
            n_bad++;
            $display("FAIL stall_drop: ovf=%b valid=%b code=%0d stable=%h want 1/1/2/0C",
                     ovf, evt_valid, evt_code, key_stable);
        end
        evt_ready = 1'b1;
        tick();
        n_cmp++;
        if (evt_valid !== 1'b0 || ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_accept: valid=%b ovf=%b want 0/1", evt_valid, ovf);
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        bit seen;
        evt_ready = 1'b1;
        key_in = 8'h20;
        exp_q.push_back(3'd5);
        wait_valid(D + 6, seen);
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL seq_key5_timeout: valid=%b want 1", evt_valid);
        end
        score_event("seq_key5");
        tick();
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL seq_key5_done: valid=%b want 0", evt_valid);
        end
        key_in = 8'h60;
        exp_q.push_back(3'd6);
        wait_valid(D + 6, seen);
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL seq_key6_timeout: valid=%b want 1", evt_valid);
        end
        score_event("seq_key6");
        go_idle();

        // Hold an event, then let a new rise land on the completing edge.
        key_in = 8'h02;
        exp_q.push_back(3'd1);
        wait_valid(D + 6, seen);
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL b2b_first_timeout: valid=%b want 1", evt_valid);
        end
        score_event("b2b_first");
        key_in = 8'h0A;
        exp_q.push_back(3'd3);
        repeat (D + 2) tick();
        evt_ready = 1'b1;
        tick();
        n_cmp++;
        if (evt_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_no_bubble: valid=%b want 1", evt_valid);
        end
        score_event("b2b_second");
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_ovf: ovf=%b want 0", ovf);
        end
        tick();
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_done: valid=%b want 0", evt_valid);
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        bit seen;
        key_in = 8'h02;
        exp_q.push_back(3'd1);
        wait_valid(D + 6, seen);
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL pre_reset_timeout: valid=%b want 1", evt_valid);
        end
        score_event("pre_reset");
        rst = 1'b1;
        #1;
        n_cmp++;
        if (evt_valid !== 1'b0 || evt_code !== 3'd0 || key_stable !== 8'h00 || any_pressed !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: valid=%b code=%0d stable=%h any=%b want 0/0/00/0",
                     evt_valid, evt_code, key_stable, any_pressed);
        end
        repeat (2) tick();
        rst = 1'b0;
        exp_q.push_back(3'd1);
        repeat (D + 2) tick();
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_redebounce_early: valid=%b want 0", evt_valid);
        end
        tick();
        n_cmp++;
        if (evt_valid !== 1'b1 || key_stable !== 8'h02) begin
            n_bad++;
            $display("FAIL reset_redebounce: valid=%b stable=%h want 1/02", evt_valid, key_stable);
        end
        score_event("post_reset");
        go_idle();
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_multi_press();
        test_drop_when_stalled();
        test_back_to_back();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expected events never seen, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
